// File: rtl/pp_pkg.sv
// Shared constants and FSM state type for the 78x78 partial-product accumulator.
package pp_pkg;

    localparam int unsigned RADIX    = 78;
    localparam int unsigned A_LIMB_W = 26;
    localparam int unsigned B_LIMB_W = 17;
    localparam int unsigned N_A_LIMB = 3;
    localparam int unsigned N_B_LIMB = 5;
    localparam int unsigned N_PP     = N_A_LIMB * N_B_LIMB;
    localparam int unsigned PP_W     = 43;
    localparam int unsigned ROW_W    = PP_W + 68;
    localparam int unsigned PROD_W   = 156;

    // Top b-limb is only 10 bits, so its partial products never reach bit 36.
    localparam int unsigned CHK_LO   = 36;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/pp_row_sum.sv
// Combinational shift-add of one a-limb row: sum of pp[k] << (17*k), k=0..4.
module pp_row_sum
    import pp_pkg::*;
(
    input  logic [PP_W-1:0]  pp [N_B_LIMB],
    output logic [ROW_W-1:0] row_sum
);

    always_comb begin
        row_sum = '0;
        for (int unsigned k = 0; k < N_B_LIMB; k++) begin
            row_sum = row_sum + (ROW_W'(pp[k]) << (B_LIMB_W * k));
        end
    end

endmodule

// File: rtl/pp_accum.sv
// Recombines 15 limb partial products into a 156-bit product over three ACC cycles.
// Optional range check enabled by macro PP_ACCUM_RANGE_CHK_EN.
module pp_accum
    import pp_pkg::*;
#(
    parameter int unsigned RADIX = pp_pkg::RADIX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PP_W-1:0]   res_0,
    input  logic [PP_W-1:0]   res_1,
    input  logic [PP_W-1:0]   res_2,
    input  logic [PP_W-1:0]   res_3,
    input  logic [PP_W-1:0]   res_4,
    input  logic [PP_W-1:0]   res_5,
    input  logic [PP_W-1:0]   res_6,
    input  logic [PP_W-1:0]   res_7,
    input  logic [PP_W-1:0]   res_8,
    input  logic [PP_W-1:0]   res_9,
    input  logic [PP_W-1:0]   res_10,
    input  logic [PP_W-1:0]   res_11,
    input  logic [PP_W-1:0]   res_12,
    input  logic [PP_W-1:0]   res_13,
    input  logic [PP_W-1:0]   res_14,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] prod,
    output logic              err
);

    if (RADIX != A_LIMB_W * N_A_LIMB) begin : g_radix_chk
        $error("pp_accum: RADIX must equal A_LIMB_W*N_A_LIMB");
    end

    state_t              state;
    logic [1:0]          row;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   acc_next;
    logic [PROD_W-1:0]   term;
    logic [ROW_W-1:0]    row_sum;
    logic [PP_W-1:0]     res_in  [N_PP];
    logic [PP_W-1:0]     res_q   [N_PP];
    logic [PP_W-1:0]     row_pp  [N_B_LIMB];

    assign res_in[0]  = res_0;
    assign res_in[1]  = res_1;
    assign res_in[2]  = res_2;
    assign res_in[3]  = res_3;
    assign res_in[4]  = res_4;
    assign res_in[5]  = res_5;
    assign res_in[6]  = res_6;
    assign res_in[7]  = res_7;
    assign res_in[8]  = res_8;
    assign res_in[9]  = res_9;
    assign res_in[10] = res_10;
    assign res_in[11] = res_11;
    assign res_in[12] = res_12;
    assign res_in[13] = res_13;
    assign res_in[14] = res_14;

    always_comb begin
        for (int unsigned k = 0; k < N_B_LIMB; k++) begin
            case (row)
                2'd1:    row_pp[k] = res_q[N_B_LIMB + k];
                2'd2:    row_pp[k] = res_q[2 * N_B_LIMB + k];
                default: row_pp[k] = res_q[k];
            endcase
        end
    end

    pp_row_sum u_row_sum (
        .pp      (row_pp),
        .row_sum (row_sum)
    );

    // Row j carries weight 2^(26*j); bits beyond 156 are discarded (mod 2^156).
    always_comb begin
        case (row)
            2'd1:    term = PROD_W'(row_sum) << A_LIMB_W;
            2'd2:    term = PROD_W'(row_sum) << (2 * A_LIMB_W);
            default: term = PROD_W'(row_sum);
        endcase
        acc_next = acc + term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            acc       <= '0;
            prod      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            for (int unsigned i = 0; i < N_PP; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < N_PP; i++) begin
                            res_q[i] <= res_in[i];
                        end
                        acc      <= '0;
                        row      <= '0;
                        in_ready <= 1'b0;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    if (row == 2'd2) begin
                        prod      <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        row <= row + 2'd1;
                    end
                end
                DONE: begin
                    // in_ready rises only after this edge, so no accept in the handshake cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef PP_ACCUM_RANGE_CHK_EN
    logic range_bad;

    assign range_bad = (|res_4[PP_W-1:CHK_LO]) | (|res_9[PP_W-1:CHK_LO]) |
                       (|res_14[PP_W-1:CHK_LO]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == IDLE && in_valid && range_bad) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/pp_accum.md
PP_ACCUM -- requirements
Module: pp_accum

Interface
REQ-001 SHALL have parameter RADIX, default 78, the operand width whose 15 partial products are recombined.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: res_0..res_14 hold a valid product set.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a set this cycle.
REQ-006 SHALL have ports res_0..res_14, input, 43 bits each; res_i = a-limb (i/5) times b-limb (i%5).
REQ-007 SHALL have port out_valid, output, 1 bit: prod is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts prod.
REQ-009 SHALL have port prod, output, 156 bits: the recombined full product a*b.
REQ-010 SHALL have port err, output, 1 bit: sticky range-check flag (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, ACC and DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-013 SHALL, on the edge where in_valid&in_ready, register all 15 inputs, clear the accumulator, set row=0 and go to ACC; inputs need not be held afterwards.
REQ-014 SHALL, in ACC, add on each edge row_sum(row) << (26*row) to the accumulator, where row_sum(j) = sum over k=0..4 of res_(5j+k) << (17k).
REQ-015 SHALL advance row 0->1->2 and go to DONE on the edge that adds row 2.
REQ-016 SHALL give a fixed latency: out_valid rises 3 edges after the accept edge, with prod = a*b.
REQ-017 SHALL compute the accumulator modulo 2^156, with no saturation.
REQ-018 SHALL hold prod and out_valid stable in DONE until out_valid&out_ready, then go to IDLE on that edge.
REQ-019 SHALL not accept new input in the DONE handshake cycle; in_ready rises the following cycle, so the minimum initiation interval is 5 cycles.
REQ-020 SHALL keep prod holding its last result in IDLE and ACC; only the DONE-to-IDLE transition changes out_valid.
REQ-021 SHALL ignore in_valid outside IDLE.

Reset
REQ-022 SHALL, while rst=1 and regardless of clk, force: state IDLE, row=0, accumulator and prod=0, out_valid=0, in_ready=1, err=0, captured inputs=0.
REQ-023 SHALL, on reset asserted mid-ACC or mid-DONE, drop the in-flight result with no output handshake.
REQ-024 SHALL accept a set on the first edge after rst deasserts if in_valid=1.

Configuration
REQ-025 SHALL, with macro PP_ACCUM_RANGE_CHK_EN defined, on each accept edge set err=1 when any of res_4, res_9 or res_14 has a nonzero bit in [42:36], since the top b-limb is only 10 bits wide.
REQ-026 SHALL keep err set until rst.
REQ-027 SHALL, with PP_ACCUM_RANGE_CHK_EN undefined, tie err to 0 and include no check logic.
REQ-028 SHALL leave prod unaffected by the range check in either case.

Structure
REQ-029 SHALL take its constants from shared package pp_pkg: RADIX=78, A_LIMB_W=26, B_LIMB_W=17, N_A_LIMB=3, N_B_LIMB=5, PP_W=43, PROD_W=156, and the FSM state enum.
REQ-030 SHALL instantiate one combinational sub-module, pp_row_sum, which shift-adds 5 PP_W inputs into one row sum of PP_W+68 bits.

Verification
REQ-031 SHALL cover: res_0=1, all others 0, accept -> out_valid 3 edges later, prod=1.
REQ-032 SHALL cover: products of limbs for a=b=2^78-1, i.e. 26- by 17-bit ones, with limb 4 at 10 bits -> prod=(2^78-1)^2.
REQ-033 SHALL cover: a=b=2^77 (res_14=2^34, others 0) -> prod=2^154.
REQ-034 SHALL cover: out_ready low 6 cycles in DONE -> prod and out_valid stable and in_ready=0; handshake -> in_ready=1 next cycle; a back-to-back second set yields a correct second result.
REQ-035 SHALL cover: rst pulse one cycle after accept -> out_valid=0, prod=0, in_ready=1, with no spurious output afterwards.
REQ-036 SHALL cover, with the macro defined: res_9=2^36 -> err=1 after the accept edge, held through later clean sets until rst; with the macro undefined the same stimulus -> err=0.
